// File: rtl/mul_div_unit_if.sv
// Operand/request and result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // EX stage side: issues requests, observes status and HI/LO.
    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, done, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One radix-2 iteration per cycle over 32 cycles, then a sign-correction/write-back cycle.
module mul_div_unit (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    localparam logic [2:0] OpMthi = 3'b100;
    localparam logic [2:0] OpMtlo = 3'b101;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // result (product/quotient) must be negated
    logic        neg_rem_q, neg_rem_d;   // remainder must be negated
    logic        div_zero_q, div_zero_d;
    logic [31:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
    logic [31:0] raw_rs_q, raw_rs_d;     // unmodified dividend for the divide-by-zero HI value
    logic [63:0] acc_q, acc_d;           // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept;
    logic        op_signed;
    logic        op_is_div;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] acc_iter;

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Request decode: only MULT/MULTU/DIV/DIVU enter the iterative path.
    always_comb begin
        accept    = (state_q == StIdle) && bus.start && !bus.flush && !bus.op[2];
        op_signed = !bus.op[0];
        op_is_div = bus.op[1];
        abs_rs    = (op_signed && bus.rs_val[31]) ? (32'd0 - bus.rs_val) : bus.rs_val;
        abs_rt    = (op_signed && bus.rt_val[31]) ? (32'd0 - bus.rt_val) : bus.rt_val;
    end

    // One shift-add or restoring shift-subtract step on the accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            // Bit 32 of the difference is set exactly when the shifted remainder < divisor.
            if (!div_diff[32]) begin
                acc_iter = {div_diff[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_iter = {div_shift[31:0], acc_q[30:0], 1'b0};
            end
        end else begin
            acc_iter = {mul_sum, acc_q[31:1]};
        end
    end

    // Sign correction and HI/LO selection for the write-back cycle.
    always_comb begin
        prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
        quot_fix = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        if (div_zero_q) begin
            fin_hi = raw_rs_q;
            fin_lo = 32'hFFFF_FFFF;
        end else if (is_div_q) begin
            fin_hi = rem_fix;
            fin_lo = quot_fix;
        end else begin
            fin_hi = prod_fix[63:32];
            fin_lo = prod_fix[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins from any state.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = StRun;
                StRun:   if (count_q == 5'd31) state_d = StFin;
                StFin:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        count_d    = count_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        opnd_d     = opnd_q;
        raw_rs_d   = raw_rs_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (bus.flush) begin
            busy_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        is_div_d   = op_is_div;
                        neg_res_d  = op_signed && (bus.rs_val[31] ^ bus.rt_val[31]);
                        neg_rem_d  = op_signed && bus.rs_val[31];
                        div_zero_d = op_is_div && (bus.rt_val == 32'd0);
                        raw_rs_d   = bus.rs_val;
                        opnd_d     = op_is_div ? abs_rt : abs_rs;
                        acc_d      = {32'd0, op_is_div ? abs_rs : abs_rt};
                        count_d    = 5'd0;
                        busy_d     = 1'b1;
                    end else if (bus.start && (bus.op == OpMthi)) begin
                        hi_d = bus.rs_val;
                    end else if (bus.start && (bus.op == OpMtlo)) begin
                        lo_d = bus.rs_val;
                    end
                end
                StRun: begin
                    acc_d   = acc_iter;
                    count_d = count_q + 5'd1;
                end
                StFin: begin
                    hi_d   = fin_hi;
                    lo_d   = fin_lo;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                default: begin
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 5'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= 32'd0;
            raw_rs_q   <= 32'd0;
            acc_q      <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            opnd_q     <= opnd_d;
            raw_rs_q   <= raw_rs_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: transaction-level reference model plus directed literals.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an operation as {hi, lo}.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint p;
        int     sa;
        int     sb;
        logic [63:0] r;
        sa = a;
        sb = b;
        r  = 64'd0;
        case (op)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                r = p;
            end
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0)                                  r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Reference model: a busy operation completes 33 edges after acceptance.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_busy, m_done;
    int          left;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        logic [63:0] res;
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0; left = 0;
        end else begin
            m_done = 1'b0;
            if (bus.flush) begin
                m_busy = 1'b0;
                left   = 0;
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
                end
            end else if (bus.start) begin
                if (bus.op < 3'd4) begin
                    res    = ref_op(bus.op, bus.rs_val, bus.rt_val);
                    p_hi   = res[63:32];
                    p_lo   = res[31:0];
                    left   = 33;
                    m_busy = 1'b1;
                end else if (bus.op == 3'd4) begin
                    m_hi = bus.rs_val;
                end else if (bus.op == 3'd5) begin
                    m_lo = bus.rs_val;
                end
            end
        end
    end

    // Compare process: outputs checked against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end
    end

    task automatic drive(input bit st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit fl);
        @(negedge clk);
        bus.start  = st;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.flush  = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    endtask

    // Returns at the negedge where done is seen; counts busy cycles on the way.
    task automatic wait_done(output int nb);
        bit seen;
        nb   = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = 1'b0;
            if (bus.busy) nb++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_done timeout actual=no_done required=done");
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string name);
        int nb;
        drive(1'b1, op, a, b, 1'b0);
        wait_done(nb);
        check({name, "_busy_cycles"}, nb, 32'd33);
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        int nb;
        int dn;
        logic [63:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;

        bus.start = 1'b0; bus.op = 3'd7; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
        bus.flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        drive(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        drive(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
        idle(1);
        check("mthi", bus.hi, 32'h1234_5678);
        check("mtlo", bus.lo, 32'h9ABC_DEF0);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
        run_op(3'd3, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF, "divu_zero");
        run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");

        // Flush mid-run leaves HI/LO untouched and produces no done.
        drive(1'b1, 3'd4, 32'hAA, 32'd0, 1'b0);
        drive(1'b1, 3'd5, 32'hBB, 32'd0, 1'b0);
        drive(1'b1, 3'd0, 32'd5, 32'd6, 1'b0);
        idle(10);
        drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b1);
        idle(1);
        check("flush_busy", 32'(bus.busy), 32'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (bus.done) dn++;
        end
        check("flush_no_done", dn, 32'd0);
        check("flush_hi", bus.hi, 32'hAA);
        check("flush_lo", bus.lo, 32'hBB);
        drive(1'b1, 3'd0, 32'd5, 32'd6, 1'b1);
        idle(1);
        check("start_flush_busy", 32'(bus.busy), 32'd0);
        drive(1'b1, 3'd4, 32'h55, 32'd0, 1'b1);
        idle(1);
        check("mthi_flush_hi", bus.hi, 32'hAA);

        // Requests while busy are ignored.
        drive(1'b1, 3'd2, 32'd1000, 32'hFFFF_FFFD, 1'b0);
        idle(3);
        drive(1'b1, 3'd1, 32'd7, 32'd7, 1'b0);
        drive(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        wait_done(nb);
        check("busy_div_lo", bus.lo, 32'hFFFF_FEB3);
        check("busy_div_hi", bus.hi, 32'd1);

        // Back-to-back start in the done cycle.
        bus.start = 1'b1; bus.op = 3'd1; bus.rs_val = 32'd123456; bus.rt_val = 32'd654321;
        wait_done(nb);
        r = ref_op(3'd1, 32'd123456, 32'd654321);
        check("b2b_busy_cycles", nb, 32'd33);
        check("b2b_hi", bus.hi, r[63:32]);
        check("b2b_lo", bus.lo, r[31:0]);

        // Reset mid-run.
        drive(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
        idle(5);
        rst = 1'b1;
        idle(1);
        check("rst_run_busy", 32'(bus.busy), 32'd0);
        check("rst_run_done", 32'(bus.done), 32'd0);
        check("rst_run_hi", bus.hi, 32'd0);
        check("rst_run_lo", bus.lo, 32'd0);
        rst = 1'b0;

        // Random traffic; the model checks every cycle.
        for (int i = 0; i < 2500; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            drive(($urandom_range(0, 3) == 0), op, a, b, ($urandom_range(0, 59) == 0));
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in the EX stage beside the ALU and consumes operands and the decoded operation from the ID/EX register. The hazard unit holds the front of the pipeline while `busy` is high. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- No parameters; datapath fixed at 32 bits, 32 iterations.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request from EX; sampled only when `busy`=0.
- `op`  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111 are no-ops.
- `rs_val`  in  32  multiplicand / dividend / MTHI-MTLO source.
- `rt_val`  in  32  multiplier / divisor.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `busy`  out  1  registered; high while an operation is in flight.
- `done`  out  1  registered one-cycle pulse when HI/LO are written by MULT/MULTU/DIV/DIVU.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, iteration count 0. Reset overrides every other input.
- States: IDLE, RUN, FIN.
- IDLE, `start`=1, op in {000..011}, `flush`=0:
  - Latch operands. Signed ops latch absolute values plus a result-sign flag and a remainder-sign flag.
  - Clear the accumulator, count=0, go to RUN.
- IDLE, `start`=1, op=100: `hi`<=`rs_val`. op=101: `lo`<=`rs_val`. Stay in IDLE, no `done`.
- RUN: one iteration per cycle.
  - Multiply: radix-2 shift-add into a 64-bit product.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - After the 32nd iteration (count=31), go to FIN.
- FIN:
  - Apply sign correction. Product is negated if operand signs differ. Quotient is negated if signs differ. Remainder takes the sign of the dividend.
  - Write HI/LO. Multiply: HI=product[63:32], LO=product[31:0]. Divide: LO=quotient, HI=remainder.
  - Pulse `done`, return to IDLE.
- Divide by zero: no trap. LO=0xFFFFFFFF, HI=`rs_val`, for both DIV and DIVU. No sign correction is applied to either.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `flush`=1 in any state: go to IDLE, `busy`=0 next cycle, HI/LO unchanged, no `done`. A `start` in the same cycle is ignored, including MTHI/MTLO.
- `start` while `busy`=1 is ignored; the operation in flight is not disturbed.
- All arithmetic is modulo 2^32 per register; no overflow flags.

## Timing
- `start` accepted at edge N:
  - `busy`=1 from N to N+33.
  - RUN at edges N+1..N+32.
  - FIN at edge N+33: HI/LO updated, `busy`=0, `done`=1.
  - `done` returns to 0 at edge N+34.
- Total: 33 busy cycles; results readable in the cycle after edge N+33.
- A new `start` may be accepted at edge N+34. A `start` presented in the cycle where `done`=1 is legal.
- MTHI/MTLO: written at the accepting edge, readable the next cycle; `busy` never asserts.
- `busy` and `done` are pure register outputs, with no combinational path from inputs.

## Test plan
- Reset, then check `hi`=`lo`=0, `busy`=0, `done`=0. MTHI 0x12345678 then MTLO 0x9ABCDEF0 → `hi`=0x12345678, `lo`=0x9ABCDEF0, `busy` never high.
- MULT rs=0xFFFFFFFE, rt=3 → after 33 busy cycles, `done` pulse, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100/7 → `lo`=14, `hi`=2.
- DIVU rs=0x64, rt=0 → `lo`=0xFFFFFFFF, `hi`=0x64. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Start MULT 5×6 with `hi`/`lo` preloaded to 0xAA/0xBB. Assert `flush` 10 cycles in → `busy`=0 the next cycle, `hi`/`lo` remain 0xAA/0xBB, no `done`. Then `start` with `flush` in the same cycle → ignored.
- During a running DIV, pulse `start` with MULTU and with MTHI → both ignored, DIV result correct. Back-to-back `start` in the `done` cycle → accepted, second result correct. Assert `rst` mid-RUN → all outputs 0 next cycle.
